uart_reporter: RTL

- Transmit-side companion to the game's UART keyboard input path. Drives the tx side of the shared uart instance (transmit, tx_byte) so the host terminal sees game status as ASCII lines.
- Two message types:
  - Score report: "SCORE=ddddd\r\n", 13 bytes, 5 zero-padded decimal digits.
  - Game-over notice: "GAME OVER\r\n", 11 bytes.
- Binary-to-BCD conversion is done sequentially. Requests arriving while busy are buffered one-deep per message type.

---
 rtl/uart_reporter_if.sv | 27 ++
 rtl/uart_reporter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_reporter_if.sv
// uart_reporter_if
//   Bundles the request side (score_req/score/over_req), the uart tx side
//   (transmit/tx_byte/is_transmitting) and the status flags (busy/dropped)
//   of the uart_reporter block.
//   master : the environment (game logic + uart) driving requests and
//            is_transmitting.
//   slave  : the uart_reporter itself.
interface uart_reporter_if;
    logic        score_req;
    logic [15:0] score;
    logic        over_req;
    logic        is_transmitting;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        busy;
    logic        dropped;

    modport master (
        output score_req, score, over_req, is_transmitting,
        input  transmit, tx_byte, busy, dropped
    );

    modport slave (
        input  score_req, score, over_req, is_transmitting,
        output transmit, tx_byte, busy, dropped
    );
endinterface

// File: rtl/uart_reporter.sv
// uart_reporter
//   Sends game status to the host terminal as ASCII lines over the shared
//   uart tx path: "SCORE=ddddd\r\n" (sequential binary-to-BCD conversion)
//   and "GAME OVER\r\n". One pending request per message type is buffered
//   while a message is in flight.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high
//   bus  - uart_reporter_if.slave: score_req/score/over_req requests,
//          is_transmitting from the uart, transmit/tx_byte to the uart,
//          busy and dropped status.
module uart_reporter #(
    parameter int START_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst,
    uart_reporter_if.slave  bus
);
    localparam int TMO_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE, CONVERT, LOAD, PULSE, WAIT_START, WAIT_DONE, NEXT
    } state_t;

    state_t             state_q, state_d;
    logic               pend_score_q, pend_score_d;
    logic               pend_over_q, pend_over_d;
    logic [15:0]        pend_val_q, pend_val_d;
    logic [15:0]        bin_q, bin_d;
    logic [19:0]        bcd_q, bcd_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [3:0]         idx_q, idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               msg_over_q, msg_over_d;   // 1 = GAME OVER message
    logic [7:0]         tx_byte_q, tx_byte_d;

    logic               consume_over;
    logic               consume_score;
    logic [19:0]        bcd_adj;
    logic [7:0]         cur_byte;
    logic [TMO_W-1:0]   tmo_inc;

    // OVER has priority when both are pending in IDLE.
    assign consume_over  = (state_q == IDLE) && pend_over_q;
    assign consume_score = (state_q == IDLE) && !pend_over_q && pend_score_q;
    assign tmo_inc       = tmo_q + 1'b1;

    // Double dabble: nibbles >= 5 get +3 before the shift.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_dabble
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 :
                                        bcd_q[gi*4 +: 4];
        end
    endgenerate

    // Byte of the current message at idx_q.
    always_comb begin
        cur_byte = 8'h00;
        if (msg_over_q) begin
            case (idx_q)
                4'd0:    cur_byte = 8'h47;   // G
                4'd1:    cur_byte = 8'h41;   // A
                4'd2:    cur_byte = 8'h4D;   // M
                4'd3:    cur_byte = 8'h45;   // E
                4'd4:    cur_byte = 8'h20;   // space
                4'd5:    cur_byte = 8'h4F;   // O
                4'd6:    cur_byte = 8'h56;   // V
                4'd7:    cur_byte = 8'h45;   // E
                4'd8:    cur_byte = 8'h52;   // R
                4'd9:    cur_byte = 8'h0D;
                4'd10:   cur_byte = 8'h0A;
                default: cur_byte = 8'h00;
            endcase
        end else begin
            case (idx_q)
                4'd0:    cur_byte = 8'h53;   // S
                4'd1:    cur_byte = 8'h43;   // C
                4'd2:    cur_byte = 8'h4F;   // O
                4'd3:    cur_byte = 8'h52;   // R
                4'd4:    cur_byte = 8'h45;   // E
                4'd5:    cur_byte = 8'h3D;   // =
                4'd6:    cur_byte = {4'h3, bcd_q[19:16]};
                4'd7:    cur_byte = {4'h3, bcd_q[15:12]};
                4'd8:    cur_byte = {4'h3, bcd_q[11:8]};
                4'd9:    cur_byte = {4'h3, bcd_q[7:4]};
                4'd10:   cur_byte = {4'h3, bcd_q[3:0]};
                4'd11:   cur_byte = 8'h0D;
                4'd12:   cur_byte = 8'h0A;
                default: cur_byte = 8'h00;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_score_q <= 1'b0;
            pend_over_q  <= 1'b0;
            pend_val_q   <= '0;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            tmo_q        <= '0;
            msg_over_q   <= 1'b0;
            tx_byte_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            pend_score_q <= pend_score_d;
            pend_over_q  <= pend_over_d;
            pend_val_q   <= pend_val_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            msg_over_q   <= msg_over_d;
            tx_byte_q    <= tx_byte_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        msg_over_d = msg_over_q;
        tx_byte_d  = tx_byte_q;

        case (state_q)
            IDLE: begin
                if (pend_over_q) begin
                    msg_over_d = 1'b1;
                    idx_d      = 4'd0;
                    state_d    = LOAD;
                end else if (pend_score_q) begin
                    bin_d      = pend_val_q;
                    bcd_d      = '0;
                    cnt_d      = 4'd0;
                    msg_over_d = 1'b0;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d = {bcd_adj[18:0], bin_q[15]};
                bin_d = {bin_q[14:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    idx_d   = 4'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_byte_d = cur_byte;
                state_d   = PULSE;
            end
            PULSE: begin
                if (!bus.is_transmitting) begin
                    tmo_d   = '0;
                    state_d = WAIT_START;
                end
            end
            WAIT_START: begin
                if (bus.is_transmitting) begin
                    state_d = WAIT_DONE;
                end else begin
                    // Uart never acknowledged: treat the byte as sent.
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_W'(START_TIMEOUT - 1)) begin
                        state_d = NEXT;
                    end
                end
            end
            WAIT_DONE: begin
                if (!bus.is_transmitting) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (idx_q == (msg_over_q ? 4'd10 : 4'd12)) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new request in the consume cycle re-arms its flag.
        pend_over_d  = bus.over_req  ? 1'b1 : (consume_over  ? 1'b0 : pend_over_q);
        pend_score_d = bus.score_req ? 1'b1 : (consume_score ? 1'b0 : pend_score_q);
        pend_val_d   = bus.score_req ? bus.score : pend_val_q;
    end

    // Outputs
    always_comb begin
        bus.transmit = (state_q == PULSE) && !bus.is_transmitting;
        bus.tx_byte  = tx_byte_q;
        bus.busy     = (state_q != IDLE) || pend_score_q || pend_over_q;
        bus.dropped  = !rst && bus.score_req && pend_score_q && !consume_score;
    end
endmodule
